channel_selector: RTL and testbench

Post-FFT channel selection stage for the polyphase channelizer, sitting between the `dit` output and downstream consumers. It tags each sample with its channel index and keeps only channels enabled in a runtime-programmable mask. Mask updates are applied glitch-free at frame boundaries. It checks frame alignment against the FFT `first` and filterbank `first_filter` markers, and can optionally resynchronise its channel counter instead of only flagging the error.

---
 rtl/channelizer_pkg.sv | 25 ++
 rtl/channel_selector_if.sv | 43 ++++
 rtl/channel_mask_reg.sv | 54 +++++
 rtl/channel_selector.sv | 166 ++++++++++++++++
 tb/tb_channel_selector.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/channelizer_pkg.sv
// -----------------------------------------------------------------------------
// channelizer_pkg
// Shared definitions for the polyphase channelizer datapath (filterbank, dit
// wrappers and the post-FFT channel selector).
//   sel_state_e       : channel selector sequencing state
//   logn_matches()    : true when n == 2**logn, used for geometry checks
//   N_DEFAULT/LOGN_*  : reference channel geometry of the channelizer
// -----------------------------------------------------------------------------
package channelizer_pkg;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } sel_state_e;

    localparam int N_DEFAULT    = 8;
    localparam int LOGN_DEFAULT = 3;

    function automatic bit logn_matches(input int n, input int logn);
        return (n == (1 << logn));
    endfunction

    localparam bit DEFAULT_GEOMETRY_OK = logn_matches(N_DEFAULT, LOGN_DEFAULT);

endpackage

// File: rtl/channel_selector_if.sv
// -----------------------------------------------------------------------------
// channel_selector_if
// Sample stream, mask configuration and status bundle of the channel selector.
//   in_*   : FFT output stream (data, valid, metadata, frame/first-filter tags)
//   cfg_*  : requested channel mask and its load strobe
//   out_*  : kept samples with channel tag, plus error / mask_busy status
// Modports:
//   master : upstream/config side (drives in_*, cfg_*)
//   slave  : the selector itself (drives out_*, error, mask_busy)
// -----------------------------------------------------------------------------
interface channel_selector_if #(
    parameter int N     = 8,
    parameter int LOGN  = 3,
    parameter int WDTH  = 32,
    parameter int MWDTH = 1
);
    logic [WDTH-1:0]  in_data;
    logic             in_nd;
    logic [MWDTH-1:0] in_m;
    logic             in_first;
    logic             in_ff;
    logic [N-1:0]     cfg_mask;
    logic             cfg_valid;

    logic [WDTH-1:0]  out_data;
    logic             out_nd;
    logic [MWDTH-1:0] out_m;
    logic [LOGN-1:0]  out_channel;
    logic             out_first;
    logic             error;
    logic             mask_busy;

    modport master (
        output in_data, in_nd, in_m, in_first, in_ff, cfg_mask, cfg_valid,
        input  out_data, out_nd, out_m, out_channel, out_first, error, mask_busy
    );

    modport slave (
        input  in_data, in_nd, in_m, in_first, in_ff, cfg_mask, cfg_valid,
        output out_data, out_nd, out_m, out_channel, out_first, error, mask_busy
    );

endinterface

// File: rtl/channel_mask_reg.sv
// -----------------------------------------------------------------------------
// channel_mask_reg
// Pending/active double buffer for the channel keep mask.
//   clk, rst_n : clock, synchronous active-low reset
//   i_load     : capture i_mask into pending (sets busy)
//   i_mask     : requested mask
//   i_commit   : frame boundary, copy pending to active (clears busy)
//   o_active   : mask used for the frame in progress
//   o_pending  : mask that the next commit will apply
//   o_busy     : a loaded mask has not been committed yet
// -----------------------------------------------------------------------------
module channel_mask_reg #(
    parameter int             N            = 8,
    parameter logic [N-1:0]   DEFAULT_MASK = {N{1'b1}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [N-1:0] i_mask,
    input  logic         i_commit,
    output logic [N-1:0] o_active,
    output logic [N-1:0] o_pending,
    output logic         o_busy
);

    logic [N-1:0] r_active;
    logic [N-1:0] r_pending;
    logic         r_busy;
    logic [N-1:0] w_next_pending;

    // A load landing on the boundary cycle is taken straight into the commit,
    // so the new mask governs the frame that starts next.
    assign w_next_pending = i_load ? i_mask : r_pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active  <= DEFAULT_MASK;
            r_pending <= DEFAULT_MASK;
            r_busy    <= 1'b0;
        end else if (i_commit) begin
            r_active  <= w_next_pending;
            r_pending <= w_next_pending;
            r_busy    <= 1'b0;
        end else if (i_load) begin
            r_pending <= i_mask;
            r_busy    <= 1'b1;
        end
    end

    assign o_active  = r_active;
    assign o_pending = r_pending;
    assign o_busy    = r_busy;

endmodule

// File: rtl/channel_selector.sv
// -----------------------------------------------------------------------------
// channel_selector
// Post-FFT channel selection: tags each sample with its channel index, keeps
// only channels enabled in the active mask, checks frame alignment against the
// first / first_filter markers and optionally resynchronises on a misplaced
// frame marker. Mask changes take effect at frame boundaries only.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : channel_selector_if.slave (input stream, config, outputs)
// Parameters: N channels (power of two, N == 2**LOGN), WDTH sample width,
// MWDTH metadata width, DEFAULT_MASK mask after reset, RESYNC realign mode.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// WAIT_SYNC | discard samples until in_first arrives (RESYNC=1 after reset)
// RUN       | counting channels, tagging and filtering every valid sample
// -----------------------------------------------------------------------------
module channel_selector
    import channelizer_pkg::*;
#(
    parameter int           N            = 8,
    parameter int           LOGN         = 3,
    parameter int           WDTH         = 32,
    parameter int           MWDTH        = 1,
    parameter logic [N-1:0] DEFAULT_MASK = {N{1'b1}},
    parameter bit           RESYNC       = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    channel_selector_if.slave    bus
);

    if (!logn_matches(N, LOGN)) begin : g_bad_geometry
        $error("channel_selector: N must equal 2**LOGN");
    end

    localparam logic [LOGN-1:0] LAST_CH = LOGN'(N - 1);

    sel_state_e       r_state;
    sel_state_e       w_state_nxt;

    logic [LOGN-1:0]  r_channel;
    logic             r_armed;
    logic             r_error;
    logic [WDTH-1:0]  r_out_data;
    logic             r_out_nd;
    logic [MWDTH-1:0] r_out_m;
    logic [LOGN-1:0]  r_out_channel;
    logic             r_out_first;

    logic             w_accept;
    logic             w_sync;
    logic             w_misplaced;
    logic             w_align_err;
    logic [LOGN-1:0]  w_eff_ch;
    logic             w_commit;
    logic [N-1:0]     w_mask_bits;
    logic             w_keep;
    logic             w_first_armed;
    logic [N-1:0]     w_active;
    logic [N-1:0]     w_pending;
    logic             w_busy;

    channel_mask_reg #(
        .N            (N),
        .DEFAULT_MASK (DEFAULT_MASK)
    ) u_mask (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (bus.cfg_valid),
        .i_mask    (bus.cfg_mask),
        .i_commit  (w_commit),
        .o_active  (w_active),
        .o_pending (w_pending),
        .o_busy    (w_busy)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RESYNC ? WAIT_SYNC : RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sync      = 1'b0;
        w_misplaced = 1'b0;
        w_align_err = 1'b0;
        w_eff_ch    = r_channel;

        case (r_state)
            WAIT_SYNC: begin
                if (bus.in_nd && bus.in_first) begin
                    w_accept    = 1'b1;
                    w_sync      = 1'b1;
                    w_eff_ch    = '0;
                    w_align_err = (bus.in_ff != bus.in_first);
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.in_nd) begin
                    w_accept    = 1'b1;
                    w_misplaced = bus.in_first && (r_channel != '0);
                    w_align_err = (bus.in_ff != bus.in_first) || w_misplaced;
                    if (RESYNC && w_misplaced) begin
                        w_sync   = 1'b1;
                        w_eff_ch = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = RESYNC ? WAIT_SYNC : RUN;
            end
        endcase

        w_commit = w_accept && (w_sync || (w_eff_ch == LAST_CH));

        // A sync sample opens a new frame, so it is filtered with the mask
        // that this same boundary makes active.
        w_mask_bits = w_sync ? w_pending : w_active;
        w_keep      = w_accept && w_mask_bits[w_eff_ch];

        // Channel 0 (by wrap or by sync) rearms out_first for the frame.
        w_first_armed = (w_eff_ch == '0) || r_armed;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_channel     <= '0;
            r_armed       <= 1'b0;
            r_error       <= 1'b0;
            r_out_data    <= '0;
            r_out_nd      <= 1'b0;
            r_out_m       <= '0;
            r_out_channel <= '0;
            r_out_first   <= 1'b0;
        end else begin
            r_out_nd    <= w_keep;
            r_out_first <= w_keep && w_first_armed;
            if (w_keep) begin
                r_out_data    <= bus.in_data;
                r_out_m       <= bus.in_m;
                r_out_channel <= w_eff_ch;
            end
            if (w_accept) begin
                r_channel <= w_eff_ch + LOGN'(1);
                r_armed   <= w_keep ? 1'b0 : w_first_armed;
            end
            if (w_align_err) begin
                r_error <= 1'b1;
            end
        end
    end

    assign bus.out_data    = r_out_data;
    assign bus.out_nd      = r_out_nd;
    assign bus.out_m       = r_out_m;
    assign bus.out_channel = r_out_channel;
    assign bus.out_first   = r_out_first;
    assign bus.error       = r_error;
    assign bus.mask_busy   = w_busy;

endmodule

// File: tb/tb_channel_selector.sv
// -----------------------------------------------------------------------------
// tb_channel_selector
// Directed bench for channel_selector: one instance with RESYNC=0 (dut0) and
// one with RESYNC=1 (dut1), sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_channel_selector;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   fr       = 0;
    int   n_out    = 0;

    channel_selector_if #(.N(8), .LOGN(3), .WDTH(32), .MWDTH(1)) bus0 ();
    channel_selector_if #(.N(8), .LOGN(3), .WDTH(32), .MWDTH(1)) bus1 ();

    channel_selector #(
        .N(8), .LOGN(3), .WDTH(32), .MWDTH(1), .DEFAULT_MASK(8'hFF), .RESYNC(1'b0)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    channel_selector #(
        .N(8), .LOGN(3), .WDTH(32), .MWDTH(1), .DEFAULT_MASK(8'hFF), .RESYNC(1'b1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus0.in_nd = 1'b0; bus0.in_first = 1'b0; bus0.in_ff = 1'b0; bus0.cfg_valid = 1'b0;
        bus1.in_nd = 1'b0; bus1.in_first = 1'b0; bus1.in_ff = 1'b0; bus1.cfg_valid = 1'b0;
    endtask

    task automatic send0(input bit first, input bit ff, input logic [31:0] d);
        bus0.in_nd = 1'b1; bus0.in_first = first; bus0.in_ff = ff;
        bus0.in_data = d; bus0.in_m = d[0];
        tick();
        bus0.cfg_valid = 1'b0;
    endtask

    task automatic send1(input bit first, input bit ff, input logic [31:0] d);
        bus1.in_nd = 1'b1; bus1.in_first = first; bus1.in_ff = ff;
        bus1.in_data = d; bus1.in_m = d[0];
        tick();
    endtask

    // One correctly aligned frame into dut0; up to two mask loads at given channels.
    task automatic run_frame0(input logic [7:0] exp_mask,
                              input int cfg_at,  input logic [7:0] cfg_m,
                              input int cfg_at2, input logic [7:0] cfg_m2);
        bit          seen;
        bit          busy_exp;
        logic [31:0] d;
        seen = 1'b0;
        busy_exp = 1'b0;
        for (int ch = 0; ch < 8; ch++) begin
            d = 32'hA000_0000 | (32'(fr) << 8) | 32'(ch);
            bus0.cfg_valid = 1'b0;
            if (ch == cfg_at) begin
                bus0.cfg_valid = 1'b1; bus0.cfg_mask = cfg_m; busy_exp = 1'b1;
            end
            if (ch == cfg_at2) begin
                bus0.cfg_valid = 1'b1; bus0.cfg_mask = cfg_m2; busy_exp = 1'b1;
            end
            send0(ch == 0, ch == 0, d);
            if (ch == 7) busy_exp = 1'b0;
            if (bus0.out_nd) n_out++;
            chk("frame_nd", bus0.out_nd, exp_mask[ch]);
            if (exp_mask[ch]) begin
                chk("frame_channel", bus0.out_channel, ch);
                chk("frame_data", bus0.out_data, d);
                chk("frame_m", bus0.out_m, d[0]);
                chk("frame_first", bus0.out_first, !seen);
                seen = 1'b1;
            end else begin
                chk("frame_first_idle", bus0.out_first, 0);
            end
            chk("frame_busy", bus0.mask_busy, busy_exp);
        end
        fr++;
    endtask

    initial begin
        bus0.in_data = '0; bus0.in_m = '0; bus0.cfg_mask = '0;
        bus1.in_data = '0; bus1.in_m = '0; bus1.cfg_mask = '0;
        idle_all();
        rst_n = 1'b0;
        tick();
        tick();

        // Reset state of both instances
        chk("rst_nd0", bus0.out_nd, 0);
        chk("rst_data0", bus0.out_data, 0);
        chk("rst_m0", bus0.out_m, 0);
        chk("rst_ch0", bus0.out_channel, 0);
        chk("rst_first0", bus0.out_first, 0);
        chk("rst_err0", bus0.error, 0);
        chk("rst_busy0", bus0.mask_busy, 0);
        chk("rst_nd1", bus1.out_nd, 0);
        chk("rst_err1", bus1.error, 0);
        chk("rst_busy1", bus1.mask_busy, 0);
        rst_n = 1'b1;
        tick();

        // Three frames with the default mask
        run_frame0(8'hFF, -1, 8'h00, -1, 8'h00);
        run_frame0(8'hFF, -1, 8'h00, -1, 8'h00);
        run_frame0(8'hFF, -1, 8'h00, -1, 8'h00);
        chk("count_24", n_out, 24);
        chk("err_after_3frames", bus0.error, 0);

        // Mid-frame load: current frame untouched, next frame channels 2 and 5
        run_frame0(8'hFF, 3, 8'b0010_0100, -1, 8'h00);
        // Load on channel 7 applies to the very next frame
        run_frame0(8'b0010_0100, 7, 8'h01, -1, 8'h00);
        run_frame0(8'h01, 7, 8'h00, -1, 8'h00);
        // All-zero mask frame; two loads, the later one wins
        run_frame0(8'h00, 2, 8'h0F, 4, 8'hFF);
        run_frame0(8'hFF, -1, 8'h00, -1, 8'h00);
        chk("err_after_mask_tests", bus0.error, 0);

        // RESYNC=0: misplaced in_first at channel 3 flags error, counter continues
        send0(1, 1, 32'h0000_0B00);
        send0(0, 0, 32'h0000_0B01);
        send0(0, 0, 32'h0000_0B02);
        chk("misp_err_before", bus0.error, 0);
        send0(1, 1, 32'h0000_0B03);
        chk("misp_err", bus0.error, 1);
        chk("misp_ch", bus0.out_channel, 3);
        chk("misp_first", bus0.out_first, 0);
        for (int ch = 4; ch < 8; ch++) begin
            send0(0, 0, 32'h0000_0B00 | 32'(ch));
            chk("misp_cont_ch", bus0.out_channel, ch);
            chk("misp_err_sticky", bus0.error, 1);
        end
        send0(1, 1, 32'h0000_0C00);
        chk("misp_wrap_ch", bus0.out_channel, 0);
        chk("misp_wrap_first", bus0.out_first, 1);
        idle_all();

        // RESYNC=1: samples before the first marker are discarded
        for (int i = 0; i < 5; i++) begin
            send1(0, 0, 32'h0000_0D00 | 32'(i));
            chk("wait_discard_nd", bus1.out_nd, 0);
        end
        send1(1, 1, 32'h0000_0E00);
        chk("sync_nd", bus1.out_nd, 1);
        chk("sync_ch", bus1.out_channel, 0);
        chk("sync_first", bus1.out_first, 1);
        chk("sync_data", bus1.out_data, 32'h0000_0E00);
        for (int ch = 1; ch < 5; ch++) begin
            send1(0, 0, 32'h0000_0E00 | 32'(ch));
            chk("sync_run_ch", bus1.out_channel, ch);
            chk("sync_run_first", bus1.out_first, 0);
        end
        chk("resync_err_before", bus1.error, 0);
        send1(1, 1, 32'h0000_0E05);
        chk("resync_err", bus1.error, 1);
        chk("resync_nd", bus1.out_nd, 1);
        chk("resync_ch", bus1.out_channel, 0);
        chk("resync_first", bus1.out_first, 1);
        chk("resync_data", bus1.out_data, 32'h0000_0E05);
        send1(0, 0, 32'h0000_0E06);
        chk("resync_next_ch", bus1.out_channel, 1);
        chk("resync_next_first", bus1.out_first, 0);
        idle_all();

        // dut0 is at channel 1: run to channel 3 with a pending mask, reset at 4
        send0(0, 0, 32'h0000_0C01);
        bus0.cfg_valid = 1'b1; bus0.cfg_mask = 8'h01;
        send0(0, 0, 32'h0000_0C02);
        send0(0, 0, 32'h0000_0C03);
        chk("pre_rst_busy", bus0.mask_busy, 1);
        idle_all();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_nd", bus0.out_nd, 0);
        chk("mid_rst_data", bus0.out_data, 0);
        chk("mid_rst_ch", bus0.out_channel, 0);
        chk("mid_rst_err", bus0.error, 0);
        chk("mid_rst_busy", bus0.mask_busy, 0);
        rst_n = 1'b1;
        tick();
        run_frame0(8'hFF, -1, 8'h00, -1, 8'h00);

        // in_ff disagreeing with in_first raises the error
        send0(1, 0, 32'h0000_0F00);
        chk("ff_mismatch_err", bus0.error, 1);
        chk("ff_mismatch_ch", bus0.out_channel, 0);
        idle_all();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
